hazard_scoreboard: RTL

- Parametrised hazard and forwarding controller for the 5-stage pipeline (F, D, E, M, W).
- Replaces the hand-wired Match_* comparators and fixed forwarding encodings with a self-contained unit.
- Keeps its own E/M/W instruction records (read/write addresses, write enables, load flag) and generates forward selects for NUM_RD execute operands across NUM_WR write ports.
- Generates load-use stalls, branch flushes and a multi-cycle execute hold counter used by long multiply/divide.

---
 rtl/hazard_scoreboard_if.sv | 37 +++
 rtl/hazard_scoreboard.sv | 130 +++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_if.sv
// Decode-side request and hazard-control response bundle between the pipeline
// and hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int AW     = 4,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int MCW    = 4,
  parameter int FSW    = $clog2(2*NUM_WR+1)
);
  logic                     dec_valid;
  logic [NUM_RD*AW-1:0]     dec_ra;
  logic [NUM_RD-1:0]        dec_ra_used;
  logic [NUM_WR*AW-1:0]     dec_wa;
  logic [NUM_WR-1:0]        dec_we;
  logic                     dec_load;
  logic [MCW-1:0]           dec_mc;
  logic                     branch_taken_e;
  logic                     stall_f;
  logic                     stall_d;
  logic                     flush_d;
  logic                     flush_e;
  logic                     hold_e;
  logic                     e_first;
  logic [NUM_RD*FSW-1:0]    fwd_sel;

  modport master (
    output dec_valid, dec_ra, dec_ra_used, dec_wa, dec_we, dec_load, dec_mc,
           branch_taken_e,
    input  stall_f, stall_d, flush_d, flush_e, hold_e, e_first, fwd_sel
  );

  modport slave (
    input  dec_valid, dec_ra, dec_ra_used, dec_wa, dec_we, dec_load, dec_mc,
           branch_taken_e,
    output stall_f, stall_d, flush_d, flush_e, hold_e, e_first, fwd_sel
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Hazard/forwarding controller for the F/D/E/M/W pipeline: tracks E/M/W
// instruction records, drives forward selects, load-use stalls, flushes and
// multi-cycle execute holds.
module hazard_fwd_lane #(
  parameter int AW        = 4,
  parameter int NUM_WR    = 2,
  parameter int NOFWD_REG = 15,
  parameter int FSW       = 3
) (
  input  logic                         en,
  input  logic [AW-1:0]                ra,
  input  logic                         m_valid,
  input  logic [NUM_WR-1:0][AW-1:0]    m_wa,
  input  logic [NUM_WR-1:0]            m_we,
  input  logic                         m_load,
  input  logic                         w_valid,
  input  logic [NUM_WR-1:0][AW-1:0]    w_wa,
  input  logic [NUM_WR-1:0]            w_we,
  output logic [FSW-1:0]               sel
);
  // Scan high-to-low so lower ports win, and W before M so M wins.
  always_comb begin
    sel = '0;
    if (en && ra != AW'(NOFWD_REG)) begin
      for (int p = NUM_WR-1; p >= 0; p--)
        if (w_valid && w_we[p] && w_wa[p] == ra) sel = FSW'(1 + NUM_WR + p);
      // A load's port-0 data does not exist until W.
      for (int p = NUM_WR-1; p >= 0; p--)
        if (m_valid && m_we[p] && m_wa[p] == ra && !(m_load && p == 0))
          sel = FSW'(1 + p);
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int AW        = 4,
  parameter int NUM_RD    = 4,
  parameter int NUM_WR    = 2,
  parameter int MCW       = 4,
  parameter int NOFWD_REG = 15,
  parameter int FSW       = $clog2(2*NUM_WR+1)
) (
  input  logic            clk,
  input  logic            reset,
  hazard_scoreboard_if.slave hz
);
  typedef struct packed {
    logic                         valid;
    logic [NUM_RD-1:0][AW-1:0]    ra;
    logic [NUM_RD-1:0]            ra_used;
    logic [NUM_WR-1:0][AW-1:0]    wa;
    logic [NUM_WR-1:0]            we;
    logic                         load;
  } rec_t;

  rec_t                       r_e, r_m, r_w, d_rec;
  logic [MCW-1:0]             mc_cnt;
  logic                       e_first_q;
  logic [NUM_RD-1:0][AW-1:0]  dec_ra_w;
  logic [NUM_RD-1:0][FSW-1:0] fwd_w;
  logic                       hold, lu, lu_hit, br, fl_e, e_load;

  assign dec_ra_w = hz.dec_ra;

  always_comb begin
    d_rec         = '0;
    d_rec.valid   = 1'b1;
    d_rec.ra      = hz.dec_ra;
    d_rec.ra_used = hz.dec_ra_used;
    d_rec.wa      = hz.dec_wa;
    d_rec.we      = hz.dec_we;
    d_rec.load    = hz.dec_load;
  end

  always_comb begin
    lu_hit = 1'b0;
    for (int i = 0; i < NUM_RD; i++)
      if (hz.dec_ra_used[i] && dec_ra_w[i] == r_e.wa[0] &&
          dec_ra_w[i] != AW'(NOFWD_REG))
        lu_hit = 1'b1;
  end

  assign hold   = |mc_cnt;
  assign lu     = r_e.valid & r_e.load & r_e.we[0] & hz.dec_valid & lu_hit;
  // A taken branch only counts once E is free to retire; it then wins over lu.
  assign br     = hz.branch_taken_e & ~hold;
  assign fl_e   = ~hold & (br | lu);
  assign e_load = ~hold & ~fl_e & hz.dec_valid;

  assign hz.stall_f = hold | (lu & ~br);
  assign hz.stall_d = hold | (lu & ~br);
  assign hz.flush_d = br;
  assign hz.flush_e = fl_e;
  assign hz.hold_e  = hold;
  assign hz.e_first = e_first_q;
  assign hz.fwd_sel = fwd_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_e       <= '0;
      r_m       <= '0;
      r_w       <= '0;
      mc_cnt    <= '0;
      e_first_q <= 1'b0;
    end else begin
      r_w <= r_m;
      r_m <= hold ? '0 : r_e;
      if (!hold) r_e <= e_load ? d_rec : '0;
      mc_cnt    <= hold ? mc_cnt - 1'b1 : (e_load ? hz.dec_mc : '0);
      e_first_q <= e_load;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_lane
    hazard_fwd_lane #(
      .AW(AW), .NUM_WR(NUM_WR), .NOFWD_REG(NOFWD_REG), .FSW(FSW)
    ) u_lane (
      .en      (r_e.valid & r_e.ra_used[g]),
      .ra      (r_e.ra[g]),
      .m_valid (r_m.valid),
      .m_wa    (r_m.wa),
      .m_we    (r_m.we),
      .m_load  (r_m.load),
      .w_valid (r_w.valid),
      .w_wa    (r_w.wa),
      .w_we    (r_w.we),
      .sel     (fwd_w[g])
    );
  end
endmodule
